md_unit_ctrl: RTL and testbench

//  Sequencer for the E-stage multiply/divide resource. Owns HI/LO and models

---
 rtl/md_unit_ctrl.sv | 158 +++++++++++++++
 tb/tb_md_unit_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: owns HI/LO and holds busy for the op's fixed latency.
// Optional multiply-accumulate ops (9-12) are enabled by defining MDU_MADD_EN.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
    // the dividend's sign, and 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag  = a[31] ? (~a + 32'd1) : a;
    assign b_mag  = b[31] ? (~b + 32'd1) : b;
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign q_mag  = a_mag / ((b == 32'd0) ? 32'd1 : b_mag);
    assign r_mag  = a_mag % ((b == 32'd0) ? 32'd1 : b_mag);
    assign quot_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = a[31] ? (~r_mag + 32'd1) : r_mag;
    assign quot_u = a / b_safe;
    assign rem_u  = a % b_safe;

    assign accept = start & ~cancel & (state_q == IDLE);

    // NOTE: every comb output gets a default up front so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            {p_hi_d, p_lo_d} = prod_s;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {p_hi_d, p_lo_d} = prod_u;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still takes the full latency but leaves HI/LO as they were.
                            if (b == 32'd0)
                                {p_hi_d, p_lo_d} = {hi_q, lo_q};
                            else if (op == OP_DIV)
                                {p_hi_d, p_lo_d} = {rem_s, quot_s};
                            else
                                {p_hi_d, p_lo_d} = {rem_u, quot_u};
                            count_d = DIV_LOAD;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            if (op == OP_MADD)
                                {p_hi_d, p_lo_d} = {hi_q, lo_q} + prod_s;
                            else if (op == OP_MADDU)
                                {p_hi_d, p_lo_d} = {hi_q, lo_q} + prod_u;
                            else if (op == OP_MSUB)
                                {p_hi_d, p_lo_d} = {hi_q, lo_q} - prod_s;
                            else
                                {p_hi_d, p_lo_d} = {hi_q, lo_q} - prod_u;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (count_q == '0) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected HI/LO and busy length are queued at
// issue time from a behavioural model and compared when busy falls.
module tb_md_unit_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd10;

    logic        clk, reset, start, cancel, busy;
    logic [3:0]  op;
    logic [31:0] a, b, out, hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          passed = 0;
    int          total  = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          obs_n;
    logic [31:0] obs_hi, obs_lo;

    md_unit_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .out(out), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] av, bv,
                                          input logic [31:0] h, l);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'(av);
        ub = longint'(bv);
        case (o)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (bv == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (bv == 32'd0) return {h, l};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            OP_MADDU: return {h, l} + ua * ub;
            default:  return {h, l};
        endcase
    endfunction

    // One-cycle start pulse; called and returns on a falling edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] av, bv, input logic cn);
        start = 1'b1; op = o; a = av; b = bv; cancel = cn;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = OP_NONE;
    endtask

    // Issue a latency op, queue its expectation, and wait (bounded) for busy to drop.
    task automatic run_op(input logic [3:0] o, input logic [31:0] av, bv, input string nm,
                          input bit poke);
        logic [63:0] r;
        exp_t        x;
        r = model(o, av, bv, m_hi, m_lo);
        x.hi = r[63:32];
        x.lo = r[31:0];
        x.cyc = (o == OP_DIV || o == OP_DIVU) ? DIV_CYCLES : MULT_CYCLES;
        x.name = nm;
        sb_q.push_back(x);
        issue(o, av, bv, 1'b0);
        obs_n = 0;
        while (busy === 1'b1 && obs_n < 200) begin
            start = 1'b0; cancel = 1'b0; op = OP_NONE;
            if (poke && obs_n == 3) cancel = 1'b1;
            if (poke && obs_n == 5) begin
                start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
            end
            obs_n++;
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0; op = OP_NONE;
        obs_hi = hi;
        obs_lo = lo;
        m_hi = x.hi;
        m_lo = x.lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_MFHI; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total += 4;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
        if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
        if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
        if (out !== 32'd0) $display("FAIL reset_out got %h want 0", out); else passed++;
        op = OP_NONE;
    endtask

    task automatic test_mthi_mf();
        issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        m_hi = 32'h0000_1234;
        total += 4;
        if (busy !== 1'b0) $display("FAIL mthi_busy got %0b want 0", busy); else passed++;
        if (hi !== 32'h0000_1234) $display("FAIL mthi_hi got %h want 00001234", hi); else passed++;
        op = OP_MFLO; #1;
        if (out !== 32'd0) $display("FAIL mflo_out got %h want 0", out); else passed++;
        op = OP_MFHI; #1;
        if (out !== 32'h0000_1234) $display("FAIL mfhi_out got %h want 00001234", out); else passed++;
        op = OP_NONE;
        @(negedge clk);
    endtask

    task automatic check_pop();
        e = sb_q.pop_front();
        total += 3;
        if (obs_n !== e.cyc) $display("FAIL %s_busy_cycles got %0d want %0d", e.name, obs_n, e.cyc);
        else passed++;
        if (obs_hi !== e.hi) $display("FAIL %s_hi got %h want %h", e.name, obs_hi, e.hi); else passed++;
        if (obs_lo !== e.lo) $display("FAIL %s_lo got %h want %h", e.name, obs_lo, e.lo); else passed++;
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0);
        check_pop();
        total += 2;
        if (obs_hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi_const got %h want ffffffff", obs_hi); else passed++;
        if (obs_lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo_const got %h want ffffffeb", obs_lo); else passed++;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        check_pop();
    endtask

    task automatic test_div();
        run_op(OP_DIVU, 32'd100, 32'd7, "divu", 1'b0);
        check_pop();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
        check_pop();
        total += 2;
        if (obs_lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo_const got %h want fffffffd", obs_lo); else passed++;
        if (obs_hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi_const got %h want ffffffff", obs_hi); else passed++;
    endtask

    task automatic test_cancel();
        issue(OP_MULT, 32'd9, 32'd9, 1'b1);
        total += 3;
        if (busy !== 1'b0) $display("FAIL cancel_busy got %0b want 0", busy); else passed++;
        if (hi !== m_hi) $display("FAIL cancel_hi got %h want %h", hi, m_hi); else passed++;
        if (lo !== m_lo) $display("FAIL cancel_lo got %h want %h", lo, m_lo); else passed++;
        run_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, "div_cancel_mid", 1'b1);
        check_pop();
    endtask

    task automatic test_div_zero();
        issue(OP_MTHI, 32'd5, 32'd0, 1'b0);
        issue(OP_MTLO, 32'd6, 32'd0, 1'b0);
        m_hi = 32'd5;
        m_lo = 32'd6;
        run_op(OP_DIV, 32'd9, 32'd0, "div_by_zero", 1'b0);
        check_pop();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
        check_pop();
        total += 2;
        if (obs_lo !== 32'h8000_0000) $display("FAIL div_overflow_lo_const got %h want 80000000", obs_lo); else passed++;
        if (obs_hi !== 32'd0) $display("FAIL div_overflow_hi_const got %h want 0", obs_hi); else passed++;
    endtask

    task automatic test_unknown_op();
        issue(4'd13, 32'h1111_1111, 32'h2222_2222, 1'b0);
`ifndef MDU_MADD_EN
        issue(4'd9, 32'h3333_3333, 32'h4444_4444, 1'b0);
`endif
        total += 3;
        if (busy !== 1'b0) $display("FAIL unknown_busy got %0b want 0", busy); else passed++;
        if (hi !== m_hi) $display("FAIL unknown_hi got %h want %h", hi, m_hi); else passed++;
        if (lo !== m_lo) $display("FAIL unknown_lo got %h want %h", lo, m_lo); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] av, bv;
        for (int i = 0; i < 6; i++) begin
            o  = 4'($urandom_range(1, 4));
            av = $urandom();
            bv = (i == 2) ? 32'd0 : $urandom();
            run_op(o, av, bv, "b2b", 1'b0);
            check_pop();
        end
    endtask

    task automatic test_reset_abort();
        issue(OP_MULT, 32'd123, 32'd456, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total += 3;
        if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else passed++;
        if (hi !== 32'd0) $display("FAIL abort_hi got %h want 0", hi); else passed++;
        if (lo !== 32'd0) $display("FAIL abort_lo got %h want 0", lo); else passed++;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (MULT_CYCLES + 2) @(negedge clk);
        total += 2;
        if (hi !== 32'd0) $display("FAIL abort_late_hi got %h want 0", hi); else passed++;
        if (lo !== 32'd0) $display("FAIL abort_late_lo got %h want 0", lo); else passed++;
`ifdef MDU_MADD_EN
        issue(OP_MTLO, 32'd10, 32'd0, 1'b0);
        m_lo = 32'd10;
        run_op(OP_MADDU, 32'd3, 32'd4, "maddu", 1'b0);
        check_pop();
        total += 1;
        if (obs_lo !== 32'd22) $display("FAIL maddu_lo_const got %h want 16", obs_lo); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_mthi_mf();
        test_mult();
        test_div();
        test_cancel();
        test_div_zero();
        test_unknown_op();
        test_back_to_back();
        test_reset_abort();
        total += 1;
        if (sb_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
